// File: rtl/me_sad_search_engine.sv
`default_nettype none
// ============================================================================
// me_sad_search_engine
// Exhaustive +/-RANGE block-matching search with multi-channel SAD, minimum
// tracking, optional early termination and a stallable vector output.
// Revision: 1.0
// ============================================================================
module me_sad_search_engine #(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 3,
  parameter int BLK      = 4,
  parameter int RANGE    = 2,
  parameter int ADDR_W   = 14,
  localparam int W       = BLK + 2*RANGE,
  localparam int SAD_W   = PIX_W + $clog2(BLK*BLK*CHANNELS),
  localparam int VEC_W   = $clog2(RANGE+1) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         ref_base,
  input  logic [ADDR_W-1:0]         act_base,
  input  logic                      early_en,
  input  logic [SAD_W-1:0]          early_thresh,
  output logic [ADDR_W-1:0]         rd_addr_ref,
  input  logic [CHANNELS*PIX_W-1:0] rd_data_ref,
  output logic [ADDR_W-1:0]         rd_addr_act,
  input  logic [CHANNELS*PIX_W-1:0] rd_data_act,
  input  logic                      vec_wait,
  output logic                      vec_valid,
  output logic [VEC_W-1:0]          vec_dx,
  output logic [VEC_W-1:0]          vec_dy,
  output logic [SAD_W-1:0]          vec_sad,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                real_state
);

  localparam int OFF_W = $clog2(2*RANGE+1);
  localparam int RC_W  = (BLK > 1) ? $clog2(BLK) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DRAIN   = 3'd2,
    S_COMPARE = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t              r_state, w_next;
  logic [RC_W-1:0]     r_row, r_col;
  logic [OFF_W-1:0]    r_ox, r_oy;          // offsets biased by +RANGE
  logic [OFF_W-1:0]    r_best_ox, r_best_oy;
  logic [ADDR_W-1:0]   r_ref_base, r_act_base;
  logic [ADDR_W-1:0]   r_rd_addr_ref, r_rd_addr_act;
  logic [SAD_W-1:0]    r_acc, r_min_sad;
  logic                r_acc_en;
  logic [VEC_W-1:0]    r_vec_dx, r_vec_dy;
  logic [SAD_W-1:0]    r_vec_sad;

  logic                w_last_pix, w_last_cand, w_better, w_early, w_take;
  logic                w_vec_valid, w_issue;
  logic [RC_W-1:0]     w_iss_row, w_iss_col;
  logic [OFF_W-1:0]    w_iss_ox, w_iss_oy, w_fin_ox, w_fin_oy;
  logic [ADDR_W-1:0]   w_iss_rbase, w_iss_abase, w_ref_addr, w_act_addr;
  logic [SAD_W-1:0]    w_pix_sad, w_fin_sad;

  function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign w_last_pix  = (r_row == RC_W'(BLK-1)) && (r_col == RC_W'(BLK-1));
  assign w_last_cand = (r_ox == OFF_W'(2*RANGE)) && (r_oy == OFF_W'(2*RANGE));
  assign w_better    = r_acc < r_min_sad;
  assign w_early     = early_en && (r_acc <= early_thresh);
  assign w_take      = w_better || w_early;
  assign w_fin_ox    = w_take ? r_ox  : r_best_ox;
  assign w_fin_oy    = w_take ? r_oy  : r_best_oy;
  assign w_fin_sad   = w_take ? r_acc : r_min_sad;

  always_comb begin
    w_pix_sad = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_pix_sad = w_pix_sad + SAD_W'(absdiff(rd_data_act[k*PIX_W +: PIX_W],
                                             rd_data_ref[k*PIX_W +: PIX_W]));
    end
  end

  always_comb begin
    w_next      = r_state;
    w_vec_valid = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_FETCH;
      S_FETCH:   if (w_last_pix) w_next = S_DRAIN;
      S_DRAIN:   w_next = S_COMPARE;
      S_COMPARE: w_next = (w_early || w_last_cand) ? S_OUTPUT : S_FETCH;
      S_OUTPUT: begin
        if (!vec_wait) begin
          w_vec_valid = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Address for the pixel issued in the coming cycle; registered so the RAM sees it then.
  always_comb begin
    w_issue     = 1'b0;
    w_iss_row   = r_row;
    w_iss_col   = r_col;
    w_iss_ox    = r_ox;
    w_iss_oy    = r_oy;
    w_iss_rbase = r_ref_base;
    w_iss_abase = r_act_base;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_issue     = 1'b1;
          w_iss_row   = '0;
          w_iss_col   = '0;
          w_iss_ox    = '0;
          w_iss_oy    = '0;
          w_iss_rbase = ref_base;
          w_iss_abase = act_base;
        end
      end
      S_FETCH: begin
        if (!w_last_pix) begin
          w_issue = 1'b1;
          if (r_col == RC_W'(BLK-1)) begin
            w_iss_row = r_row + RC_W'(1);
            w_iss_col = '0;
          end else begin
            w_iss_col = r_col + RC_W'(1);
          end
        end
      end
      S_COMPARE: begin
        if (w_next == S_FETCH) begin
          w_issue   = 1'b1;
          w_iss_row = '0;
          w_iss_col = '0;
          if (r_ox == OFF_W'(2*RANGE)) begin
            w_iss_ox = '0;
            w_iss_oy = r_oy + OFF_W'(1);
          end else begin
            w_iss_ox = r_ox + OFF_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign w_ref_addr = ADDR_W'(32'(w_iss_rbase) + (32'(w_iss_row) + 32'(w_iss_oy)) * 32'(W)
                              + 32'(w_iss_col) + 32'(w_iss_ox));
  assign w_act_addr = ADDR_W'(32'(w_iss_abase) + 32'(w_iss_row) * 32'(BLK) + 32'(w_iss_col));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_ox          <= '0;
      r_oy          <= '0;
      r_best_ox     <= '0;
      r_best_oy     <= '0;
      r_ref_base    <= '0;
      r_act_base    <= '0;
      r_rd_addr_ref <= '0;
      r_rd_addr_act <= '0;
      r_acc         <= '0;
      r_min_sad     <= '1;
      r_acc_en      <= 1'b0;
      r_vec_dx      <= '0;
      r_vec_dy      <= '0;
      r_vec_sad     <= '0;
    end else begin
      r_state  <= w_next;
      r_acc_en <= (r_state == S_FETCH);
      if (w_issue) begin
        r_row         <= w_iss_row;
        r_col         <= w_iss_col;
        r_ox          <= w_iss_ox;
        r_oy          <= w_iss_oy;
        r_ref_base    <= w_iss_rbase;
        r_act_base    <= w_iss_abase;
        r_rd_addr_ref <= w_ref_addr;
        r_rd_addr_act <= w_act_addr;
      end
      if (r_state == S_IDLE && start) begin
        r_min_sad <= '1;
        r_best_ox <= OFF_W'(RANGE);
        r_best_oy <= OFF_W'(RANGE);
      end
      // Clear on candidate entry; RAM data lags the address by one cycle.
      if (w_issue && r_state != S_FETCH) begin
        r_acc <= '0;
      end else if (r_acc_en) begin
        r_acc <= r_acc + w_pix_sad;
      end
      if (r_state == S_COMPARE && w_take) begin
        r_min_sad <= r_acc;
        r_best_ox <= r_ox;
        r_best_oy <= r_oy;
      end
      if (r_state == S_COMPARE && w_next == S_OUTPUT) begin
        r_vec_dx  <= VEC_W'(int'(w_fin_ox) - RANGE);
        r_vec_dy  <= VEC_W'(int'(w_fin_oy) - RANGE);
        r_vec_sad <= w_fin_sad;
      end
    end
  end

  assign rd_addr_ref = r_rd_addr_ref;
  assign rd_addr_act = r_rd_addr_act;
  assign vec_valid   = w_vec_valid;
  assign done        = w_vec_valid;
  assign vec_dx      = r_vec_dx;
  assign vec_dy      = r_vec_dy;
  assign vec_sad     = r_vec_sad;
  assign busy        = (r_state != S_IDLE);
  assign real_state  = r_state;

endmodule
`default_nettype wire
